// File: rtl/router_out_arbiter.sv
// ----------------------------------------------------------------------------
// router_out_arbiter
//
// Three-input round-robin output arbiter for one 3D-NoC router port.
// Each routing channel (0 straight, 1 +3 hop, 2 local) feeds a small FIFO.
// Each cycle the output register can take a packet, and one packet is granted
// in fair rotation. The granted packet goes into a registered output stage.
//
// Ports:
//   clk        single clock, rising edge
//   reset      asynchronous active-high reset
//   in_valid   [3]        per-input valid
//   in_data    [3*WIDTH]  per-input packet, slice i = [i*WIDTH +: WIDTH]
//   in_ready   [3]        per-input ready (FIFO not full)
//   out_valid             output register holds a packet
//   out_data   [WIDTH]    registered packet
//   out_src    [2]        input index of out_data, 2'd3 when idle
//   out_ready             downstream accepts the packet
//   pkt_count  [CNT_W]    packets delivered downstream (wraps)
// ----------------------------------------------------------------------------
module router_out_arbiter #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         in_valid,
    input  logic [3*WIDTH-1:0] in_data,
    output logic [2:0]         in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_src,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   pkt_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [3][DEPTH];
    logic [AW-1:0]    wr_ptr_r [3];
    logic [AW-1:0]    rd_ptr_r [3];
    logic [CW-1:0]    cnt_r [3];
    logic [1:0]       ptr_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [1:0]       out_src_r;
    logic [CNT_W-1:0] pkt_count_r;

    logic [2:0]       ready_s;
    logic [2:0]       push_s;
    logic [2:0]       pop_s;
    logic [2:0]       nonempty_s;
    logic             load_s;
    logic             grant_valid_s;
    logic [1:0]       grant_s;
    logic [1:0]       cand_s;
    logic [WIDTH-1:0] grant_data_s;

    // (base + off) mod 3 for base, off in 0..2
    function automatic logic [1:0] rot_idx(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end else begin
            sum = sum;
        end
        return sum[1:0];
    endfunction

    // FIFO status flags and handshakes; ready comes from registered count only
    always_comb begin
        ready_s    = 3'b000;
        push_s     = 3'b000;
        nonempty_s = 3'b000;
        for (int i = 0; i < 3; i++) begin
            ready_s[i]    = (cnt_r[i] != CW'(DEPTH));
            push_s[i]     = in_valid[i] && ready_s[i];
            nonempty_s[i] = (cnt_r[i] != CW'(0));
        end
    end

    assign load_s = !out_valid_r || out_ready;

    // Round-robin search: first non-empty FIFO starting at ptr_r
    always_comb begin
        grant_valid_s = 1'b0;
        grant_s       = 2'd0;
        cand_s        = 2'd0;
        for (int k = 0; k < 3; k++) begin
            cand_s = rot_idx(ptr_r, 2'(k));
            if (!grant_valid_s && nonempty_s[cand_s]) begin
                grant_valid_s = 1'b1;
                grant_s       = cand_s;
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    // Head-of-FIFO data of the granted input and per-FIFO pop strobes
    always_comb begin
        grant_data_s = mem_r[grant_s][rd_ptr_r[grant_s]];
        pop_s        = 3'b000;
        for (int i = 0; i < 3; i++) begin
            pop_s[i] = load_s && grant_valid_s && (grant_s == 2'(i));
        end
    end

    // FIFO storage; contents need no reset since counts gate every read
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (push_s[i]) begin
                mem_r[i][wr_ptr_r[i]] <= in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // FIFO pointers and occupancy counts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                wr_ptr_r[i] <= AW'(0);
                rd_ptr_r[i] <= AW'(0);
                cnt_r[i]    <= CW'(0);
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (push_s[i]) begin
                    wr_ptr_r[i] <= wr_ptr_r[i] + AW'(1);
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + AW'(1);
                end
                case ({push_s[i], pop_s[i]})
                    2'b10:   cnt_r[i] <= cnt_r[i] + CW'(1);
                    2'b01:   cnt_r[i] <= cnt_r[i] - CW'(1);
                    default: cnt_r[i] <= cnt_r[i];
                endcase
            end
        end
    end

    // Output register and rotation pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= WIDTH'(0);
            out_src_r   <= 2'd3;
            ptr_r       <= 2'd0;
        end else if (load_s) begin
            if (grant_valid_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= grant_data_s;
                out_src_r   <= grant_s;
                ptr_r       <= rot_idx(grant_s, 2'd1);
            end else begin
                out_valid_r <= 1'b0;
                out_src_r   <= 2'd3;
            end
        end
    end

    // Delivered-packet counter, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count_r <= CNT_W'(0);
        end else if (out_valid_r && out_ready) begin
            pkt_count_r <= pkt_count_r + CNT_W'(1);
        end
    end

    assign in_ready  = ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;
    assign pkt_count = pkt_count_r;

endmodule

// File: tb/tb_router_out_arbiter.sv
// ----------------------------------------------------------------------------
// tb_router_out_arbiter
//
// Directed bench for router_out_arbiter (CNT_W = 4 so wrap is reachable).
// Stimulus pushes hand-computed expected {src, data} into a queue; a monitor
// pops and compares on every delivered packet (out_valid && out_ready).
// ----------------------------------------------------------------------------
module tb_router_out_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  in_valid;
    logic [32:0] in_data;
    logic [2:0]  in_ready;
    logic        out_valid;
    logic [10:0] out_data;
    logic [1:0]  out_src;
    logic        out_ready;
    logic [3:0]  pkt_count;

    typedef struct {
        logic [1:0]  src;
        logic [10:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;

    router_out_arbiter #(.WIDTH(11), .DEPTH(4), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: sample away from the rising edge
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_pkt: got src=%0d data=%h, required no packet", out_src, out_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_src !== mon_e.src || out_data !== mon_e.data) begin
                    mismatched++;
                    $display("FAIL sb_pkt: got src=%0d data=%h, required src=%0d data=%h",
                             out_src, out_data, mon_e.src, mon_e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pkt(input logic [1:0] src, input logic [10:0] data);
        exp_t e;
        e.src  = src;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain_timeout: %0d packets outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        tick();
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 3'b000;
        in_data   = 33'd0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_src",   32'(out_src),   32'd3);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd7);
        #20;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single packet on input 2
        in_valid         = 3'b100;
        in_data[22 +: 11] = 11'h5A3;
        out_ready        = 1'b1;
        expect_pkt(2'd2, 11'h5A3);
        tick();
        in_valid = 3'b000;
        tick();
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data",  32'(out_data),  32'h5A3);
        chk("single_src",   32'(out_src),   32'd2);
        tick();
        chk("single_count", 32'(pkt_count), 32'd1);
        chk("idle_valid",   32'(out_valid), 32'd0);
        chk("idle_src",     32'(out_src),   32'd3);

        // Round-robin: preload three per input under backpressure
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid         = 3'b111;
            in_data[0 +: 11]  = 11'h100 + 11'(k);
            in_data[11 +: 11] = 11'h200 + 11'(k);
            in_data[22 +: 11] = 11'h300 + 11'(k);
            tick();
        end
        in_valid = 3'b000;
        chk("rr_hold_valid", 32'(out_valid), 32'd1);
        chk("rr_hold_src",   32'(out_src),   32'd0);
        chk("rr_hold_data",  32'(out_data),  32'h100);
        chk("rr_in_ready",   32'(in_ready),  32'd7);
        for (int k = 0; k < 3; k++) begin
            expect_pkt(2'd0, 11'h100 + 11'(k));
            expect_pkt(2'd1, 11'h200 + 11'(k));
            expect_pkt(2'd2, 11'h300 + 11'(k));
        end
        out_ready = 1'b1;
        drain(30);
        chk("rr_count", 32'(pkt_count), 32'd9);

        // Reset mid-operation: two queued on input 1, output register loaded
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid          = 3'b010;
            in_data[11 +: 11] = 11'h0A0 + 11'(k);
            tick();
        end
        in_valid = 3'b000;
        chk("mid_valid_before", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid",    32'(out_valid), 32'd0);
        chk("mid_rst_src",      32'(out_src),   32'd3);
        chk("mid_rst_count",    32'(pkt_count), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready),  32'd7);
        #2;
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("mid_no_stale", 32'(out_valid), 32'd0);
        chk("mid_count",    32'(pkt_count), 32'd0);

        // Backpressure / full FIFO on input 0
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid         = 3'b001;
            in_data[0 +: 11] = 11'h400 + 11'(k);
            chk($sformatf("bp_ready_%0d", k), 32'(in_ready[0]), 32'd1);
            tick();
        end
        in_data[0 +: 11] = 11'h7FF;
        chk("bp_full_ready", 32'(in_ready[0]), 32'd0);
        chk("bp_hold_data",  32'(out_data),    32'h400);
        chk("bp_hold_valid", 32'(out_valid),   32'd1);
        for (int k = 0; k < 5; k++) begin
            expect_pkt(2'd0, 11'h400 + 11'(k));
        end
        out_ready = 1'b1;
        chk("nobypass_ready", 32'(in_ready[0]), 32'd0);
        tick();
        out_ready = 1'b0;
        in_valid  = 3'b000;
        chk("freed_ready",  32'(in_ready[0]), 32'd1);
        chk("bp_next_data", 32'(out_data),    32'h401);
        out_ready = 1'b1;
        drain(20);
        chk("bp_count", 32'(pkt_count), 32'd5);

        // Counter wrap: 17 packets with a 4-bit counter
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            in_valid         = 3'b001;
            in_data[0 +: 11] = 11'h010 + 11'(k);
            expect_pkt(2'd0, 11'h010 + 11'(k));
            tick();
        end
        in_valid = 3'b000;
        drain(20);
        chk("wrap_count", 32'(pkt_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
